// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
package demux_pkg;

  localparam int NCH = 8;
  localparam int SW  = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage

// File: rtl/demux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last',
// wrapping around, with 'last' itself checked at lowest priority.
module rr_pick
  import demux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  last,
  output logic [SW-1:0]  pick,
  output logic           found
);

  logic [SW:0] cand;

  // Scan from the farthest offset down to the nearest one, so the nearest
  // requester after 'last' is the assignment that sticks.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = {1'b0, last} + (SW+1)'(k);
      if (cand >= (SW+1)'(NCH)) begin
        cand = cand - (SW+1)'(NCH);
      end
      if (req[cand[SW-1:0]]) begin
        pick  = cand[SW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler for the 1-to-NCH demux: grants a ready channel,
// passes BURST beats to it, and aborts a burst that stalls for too long.
module demux_rr_scheduler
  import demux_pkg::*;
#(
  parameter int DW        = 1,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic [NCH-1:0]    ch_ready,
  output logic [NCH-1:0]    ch_valid,
  output logic [NCH*DW-1:0] ch_data,
  output logic [SW-1:0]     sel,
  output logic              busy,
  output logic              abort
);

  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(STALL_MAX + 1);

  state_t          state_reg;
  logic [SW-1:0]   sel_reg;
  logic [SW-1:0]   last_reg;
  logic [BW-1:0]   beat_cnt_reg;
  logic [TW-1:0]   stall_cnt_reg;
  logic            abort_reg;

  logic [SW-1:0]   pick;
  logic            found;
  logic            xfer;
  logic            beat;
  logic            stall;

  rr_pick u_rr_pick (
    .req   (ch_ready),
    .last  (last_reg),
    .pick  (pick),
    .found (found)
  );

  // Handshake qualifiers; only the granted channel's ready matters in XFER.
  assign xfer     = (state_reg == XFER);
  assign in_ready = xfer && ch_ready[sel_reg];
  assign beat     = in_valid && in_ready;
  assign stall    = xfer && in_valid && !ch_ready[sel_reg];

  assign sel   = sel_reg;
  assign busy  = (state_reg != IDLE);
  assign abort = abort_reg;

  // Demux routing: only the selected slice follows the input, all others are 0.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_route
    assign ch_valid[gi]          = xfer && (sel_reg == SW'(gi)) && in_valid;
    assign ch_data[gi*DW +: DW]  = (xfer && (sel_reg == SW'(gi))) ? in_data : '0;
  end

  // Scheduler FSM with burst and stall counters; abort is a registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      last_reg      <= SW'(NCH - 1);
      beat_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      abort_reg     <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en && in_valid) begin
            state_reg <= ARB;
          end
        end
        ARB: begin
          if (!en || !in_valid) begin
            state_reg <= IDLE;
          end else if (found) begin
            sel_reg       <= pick;
            last_reg      <= pick;
            beat_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            state_reg     <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            stall_cnt_reg <= '0;
            if (beat_cnt_reg == BW'(BURST - 1)) begin
              state_reg <= (en && in_valid) ? ARB : IDLE;
            end
            if (beat_cnt_reg != BW'(BURST)) begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end else if (stall) begin
            // 'last' already equals sel, so the stalled channel ends up
            // at the bottom of the next arbitration.
            if (stall_cnt_reg == TW'(STALL_MAX - 1)) begin
              abort_reg <= 1'b1;
              state_reg <= ARB;
            end else begin
              stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed self-checking bench for demux_rr_scheduler.
module tb_demux_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [0:0]  in_data;
  logic        in_ready;
  logic [7:0]  ch_ready;
  logic [7:0]  ch_valid;
  logic [7:0]  ch_data;
  logic [2:0]  sel;
  logic        busy;
  logic        abort;

  int checks = 0;
  int errors = 0;

  int         rot_ch[9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  logic [7:0] rot_mask[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  int         sp_ch[3]    = '{2, 5, 2};
  logic [7:0] sp_mask[3]  = '{8'h04, 8'h20, 8'h04};

  demux_rr_scheduler #(.DW(1), .BURST(4), .STALL_MAX(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ch_ready (ch_ready),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .sel      (sel),
    .busy     (busy),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point; leaves rst_n released one sample point later.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Called at a sample point where the DUT sits in ARB with a grant due next edge.
  task automatic run_burst(input int ch, input logic [7:0] mask);
    step();
    for (int b = 0; b < 4; b++) begin
      check_eq($sformatf("sel_ch%0d_b%0d", ch, b), sel, ch);
      check_eq($sformatf("valid_ch%0d_b%0d", ch, b), ch_valid, mask);
      check_eq($sformatf("data_ch%0d_b%0d", ch, b), ch_data, mask);
      check_eq($sformatf("ready_ch%0d_b%0d", ch, b), in_ready, 1);
      step();
    end
    check_eq($sformatf("arb_gap_valid_ch%0d", ch), ch_valid, 0);
    check_eq($sformatf("arb_gap_busy_ch%0d", ch), busy, 1);
    $display("burst ch%0d beats=4 done", ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    ch_ready = 8'h00;

    // 1: reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      en       = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 1'($urandom);
      ch_ready = 8'($urandom);
      step();
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_ch_valid", ch_valid, 0);
      check_eq("rst_ch_data", ch_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_sel", sel, 0);
      check_eq("rst_abort", abort, 0);
    end
    $display("reset hold done");

    // 2: rotation over all channels
    en = 1'b1; in_valid = 1'b1; in_data = 1'b1; ch_ready = 8'hFF;
    rst_n = 1'b1;
    step();
    check_eq("rot_first_arb_busy", busy, 1);
    check_eq("rot_first_arb_valid", ch_valid, 0);
    for (int g = 0; g < 9; g++) run_burst(rot_ch[g], rot_mask[g]);

    // 3: sparse readiness, last grant was ch0
    ch_ready = 8'b0010_0100;
    for (int g = 0; g < 3; g++) run_burst(sp_ch[g], sp_mask[g]);

    // 4: stall timeout on ch3
    ch_ready = 8'h08;
    do_reset();
    step();
    check_eq("stall_arb_busy", busy, 1);
    step();
    check_eq("stall_grant_sel", sel, 3);
    check_eq("stall_grant_valid", ch_valid, 8'h08);
    check_eq("stall_grant_ready", in_ready, 1);
    step();
    ch_ready = 8'h10;
    #1;
    for (int s = 0; s < 15; s++) begin
      check_eq($sformatf("stall_ready_s%0d", s), in_ready, 0);
      check_eq($sformatf("stall_abort_s%0d", s), abort, 0);
      check_eq($sformatf("stall_valid_s%0d", s), ch_valid, 8'h08);
      step();
    end
    check_eq("abort_pulse", abort, 1);
    check_eq("abort_valid", ch_valid, 0);
    check_eq("abort_busy", busy, 1);
    $display("stall abort on ch3 observed");
    ch_ready = 8'h18;
    step();
    check_eq("after_abort_sel", sel, 4);
    check_eq("after_abort_valid", ch_valid, 8'h10);
    check_eq("abort_one_cycle", abort, 0);

    // 5: idle gaps mid-burst, then enable drop
    ch_ready = 8'hFF;
    do_reset();
    step();
    step();
    check_eq("gap_grant_valid", ch_valid, 8'h01);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("gap_valid_low", ch_valid, 0);
    for (int g = 0; g < 3; g++) begin
      step();
      check_eq($sformatf("gap_busy_%0d", g), busy, 1);
      check_eq($sformatf("gap_abort_%0d", g), abort, 0);
      check_eq($sformatf("gap_sel_%0d", g), sel, 0);
    end
    in_valid = 1'b1;
    #1;
    check_eq("gap_resume_valid", ch_valid, 8'h01);
    step();
    en = 1'b0;
    check_eq("en_drop_valid", ch_valid, 8'h01);
    step();
    check_eq("en_drop_busy_mid", busy, 1);
    check_eq("en_drop_valid_mid", ch_valid, 8'h01);
    step();
    check_eq("en_drop_idle_busy", busy, 0);
    check_eq("en_drop_idle_valid", ch_valid, 0);
    check_eq("en_drop_idle_ready", in_ready, 0);
    step();
    check_eq("en_drop_stays_idle", busy, 0);
    $display("gap and enable-drop burst done");

    // 6: async reset during beat 2
    en = 1'b1;
    do_reset();
    step();
    step();
    step();
    step();
    check_eq("mid_rst_pre_valid", ch_valid, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", ch_valid, 0);
    check_eq("async_rst_data", ch_data, 0);
    check_eq("async_rst_ready", in_ready, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_sel", sel, 0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_arb_busy", busy, 1);
    step();
    check_eq("post_rst_sel", sel, 0);
    check_eq("post_rst_valid", ch_valid, 8'h01);
    $display("async reset mid-burst done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
